fft_twiddle_agu: RTL
====================

Name: fft_twiddle_agu

Overview:
- Address-generation and twiddle-fetch sequencer for the 256-point radix-2 in-place DIT FFT core.
- On start, it walks all 8 stages × 128 butterflies.
- For each butterfly it drives the twiddle ROM address, captures the ROM output, and presents one butterfly descriptor per beat to the butterfly datapath: data indices a/b, twiddle, and stage flags.
- It sits between the FFT controller (start/done) and the butterfly unit (valid/ready).

Parameters:
- N, 256, FFT length (power of two; LOG2N = $clog2(N), HALF = N/2).
- WIDTH, 16, twiddle component width (signed Q1.(WIDTH-1)).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  pulse; begins a transform when idle
- inv_i  in  1  sampled with start_i; 1 = inverse transform (conjugate twiddles)
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse after last butterfly accepted
- rom_addr_o  out  LOG2N-1  twiddle ROM address (combinational ROM, same-cycle data)
- rom_re_i  in  WIDTH  ROM real part
- rom_im_i  in  WIDTH  ROM imaginary part
- stage_done_i  in  1  butterfly writeback of current stage complete (used only with barrier feature)
- bf_valid_o  out  1  descriptor valid
- bf_ready_i  in  1  butterfly unit accepts descriptor
- bf_idx_a_o  out  LOG2N  upper-leg data index
- bf_idx_b_o  out  LOG2N  lower-leg data index
- bf_tw_re_o  out  WIDTH  twiddle real
- bf_tw_im_o  out  WIDTH  twiddle imaginary
- bf_tw_unity_o  out  1  twiddle is exactly +1 (address 0); butterfly bypasses the multiply
- bf_stage_o  out  $clog2(LOG2N)  stage number 0..LOG2N-1
- bf_last_stage_beat_o  out  1  last butterfly of the stage
- bf_last_o  out  1  last butterfly of the transform

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; counters s = 0, j = 0; latched inv = 0.
- FSM states: IDLE, RUN, WAIT_BAR, FLUSH.
- IDLE:
  - start_i = 1 → latch inv_i, clear s/j, set busy_o, go to RUN.
  - start_i in any other state is ignored.
- Index math, combinational from (s, j):
  - half = 1<<s, p = j & (half-1), g = j >> s.
  - idx_a = (g << (s+1)) | p, idx_b = idx_a + half.
  - rom_addr_o = (p << (LOG2N-1-s)) mod HALF.
- Output stage: a single register slice. load = RUN && (!bf_valid_o || bf_ready_i). On load:
  - Capture the index/stage values and ROM data.
  - tw_unity = (rom_addr_o == 0).
  - Set bf_valid_o.
  - Advance j. On j wrap (127 → 0), increment s.
- Inverse: tw_im = -rom_im_i, saturated to +(2^(WIDTH-1)-1) when rom_im_i = -2^(WIDTH-1). tw_re passes through unchanged.
- Handshake:
  - Transfer occurs when bf_valid_o && bf_ready_i.
  - While valid && !ready, all bf_* outputs hold stable.
  - bf_valid_o never drops without a transfer.
  - No bubbles: with ready held high, one descriptor per cycle.
- After loading the beat with s = LOG2N-1 and j = HALF-1, go to FLUSH.
- FLUSH: when that beat transfers → done_o = 1 for one cycle, busy_o = 0, go to IDLE. bf_valid_o clears on that transfer.
- Latency: first descriptor valid 1 cycle after start_i. Total 1024 beats for N = 256.
- rst asserted mid-transform → next cycle IDLE, bf_valid_o = 0, busy_o = 0, no done_o.

Optional Feature:
- Macro: FFT_AGU_STAGE_BARRIER_EN.
- Defined:
  - After loading the last beat of stages 0..LOG2N-2, enter WAIT_BAR.
  - The pending descriptor still transfers normally.
  - No new load until stage_done_i = 1 is sampled (and the output slice is empty or transferring); then return to RUN with s+1.
  - A stage_done_i pulse arriving in the same cycle as entry to WAIT_BAR is honoured.
- Undefined: WAIT_BAR unreachable, stage_done_i ignored, stages issue back-to-back.

Test Plan:
- Full run, ready = 1, inv = 0:
  - 1024 beats, done_o exactly 1 cycle after beat 1023 transfers.
  - Beat 0: s = 0, a = 0, b = 1, rom_addr = 0, unity = 1.
  - Stage 1, j = 1: a = 1, b = 3, rom_addr = 64.
  - Stage 7, j = 5: a = 5, b = 133, rom_addr = 5, last_o = 0.
  - Final beat: a = 127, b = 255, last_o = 1, last_stage_beat_o = 1.
- Backpressure: drop bf_ready_i for 3 cycles at beat 10 → bf_* stable all 3 cycles, beat 10 delivered once, beat count still 1024.
- Inverse: inv_i = 1. Bench ROM returns im = -32768 at addr 64 → bf_tw_im_o = 32767. Returns im = -804 at addr 1 → +804; re unchanged.
- Control corners:
  - start_i pulsed during RUN → ignored, beat sequence unchanged.
  - rst at stage 3 beat 40 → bf_valid_o = 0 and busy_o = 0 next cycle, no done_o.
  - Restart after reset → beat 0 again.
- With FFT_AGU_STAGE_BARRIER_EN:
  - After stage-0 beat 127 transfers, bf_valid_o stays 0 for 20 cycles until stage_done_i is pulsed.
  - Next beat: s = 1, a = 0, b = 2.
  - Without the macro: stage-1 beat follows immediately.

Source files
------------

// File: rtl/fft_twiddle_agu.sv
// Address/twiddle sequencer for the radix-2 in-place DIT FFT: walks every stage x butterfly and emits one descriptor per beat.
// Optional stage barrier (wait for stage_done_i between stages) is enabled by defining FFT_AGU_STAGE_BARRIER_EN.
module fft_twiddle_agu #(
    parameter int N     = 256,
    parameter int WIDTH = 16,
    localparam int LOG2N = $clog2(N),
    localparam int SW    = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             inv_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LOG2N-2:0] rom_addr_o,
    input  logic [WIDTH-1:0] rom_re_i,
    input  logic [WIDTH-1:0] rom_im_i,
    input  logic             stage_done_i,
    output logic             bf_valid_o,
    input  logic             bf_ready_i,
    output logic [LOG2N-1:0] bf_idx_a_o,
    output logic [LOG2N-1:0] bf_idx_b_o,
    output logic [WIDTH-1:0] bf_tw_re_o,
    output logic [WIDTH-1:0] bf_tw_im_o,
    output logic             bf_tw_unity_o,
    output logic [SW-1:0]    bf_stage_o,
    output logic             bf_last_stage_beat_o,
    output logic             bf_last_o
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_BAR, FLUSH} state_t;

    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
    localparam logic [LOG2N-2:0] J_LAST = '1;
    localparam logic [WIDTH-1:0] TW_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TW_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_t            state;
    logic [SW-1:0]     s;
    logic [LOG2N-2:0]  j;
    logic              inv_q;

    logic [LOG2N-1:0]  j_ext, half_c, p_c, g_c, idx_a_c, idx_b_c;
    logic [SW:0]       s1_c;
    logic [LOG2N-2:0]  addr_c;
    logic [WIDTH-1:0]  tw_im_c;
    logic              inv_eff;
    logic              load_c;
    logic              xfer_c;

    always_comb begin
        j_ext   = {1'b0, j};
        s1_c    = {1'b0, s} + {{SW{1'b0}}, 1'b1};
        half_c  = ONE << s;
        p_c     = j_ext & (half_c - ONE);
        g_c     = j_ext >> s;
        idx_a_c = (g_c << s1_c) | p_c;
        idx_b_c = idx_a_c + half_c;
        addr_c  = p_c[LOG2N-2:0] << (S_LAST - s);
    end

    assign rom_addr_o = addr_c;

    // The beat loaded on start uses inv_i directly because inv_q is only latched on that same edge.
    always_comb begin
        inv_eff = (state == IDLE) ? inv_i : inv_q;
        tw_im_c = rom_im_i;
        if (inv_eff) begin
            if (rom_im_i == TW_MIN) tw_im_c = TW_MAX;
            else                    tw_im_c = -rom_im_i;
        end
    end

    // s and j are always zero in IDLE, so the start edge can load beat 0 straight away.
    assign xfer_c = bf_valid_o && bf_ready_i;
    assign load_c = ((state == RUN) && (!bf_valid_o || bf_ready_i)) ||
                    ((state == IDLE) && start_i);

`ifdef FFT_AGU_STAGE_BARRIER_EN
    logic bar_pend;
`else
    logic unused_stage_done;
    assign unused_stage_done = stage_done_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            s                    <= '0;
            j                    <= '0;
            inv_q                <= 1'b0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            bf_valid_o           <= 1'b0;
            bf_idx_a_o           <= '0;
            bf_idx_b_o           <= '0;
            bf_tw_re_o           <= '0;
            bf_tw_im_o           <= '0;
            bf_tw_unity_o        <= 1'b0;
            bf_stage_o           <= '0;
            bf_last_stage_beat_o <= 1'b0;
            bf_last_o            <= 1'b0;
`ifdef FFT_AGU_STAGE_BARRIER_EN
            bar_pend             <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            if (xfer_c) bf_valid_o <= 1'b0;

            if (load_c) begin
                bf_valid_o           <= 1'b1;
                bf_idx_a_o           <= idx_a_c;
                bf_idx_b_o           <= idx_b_c;
                bf_tw_re_o           <= rom_re_i;
                bf_tw_im_o           <= tw_im_c;
                bf_tw_unity_o        <= (addr_c == '0);
                bf_stage_o           <= s;
                bf_last_stage_beat_o <= (j == J_LAST);
                bf_last_o            <= (j == J_LAST) && (s == S_LAST);
                j                    <= j + 1'b1;
                if (j == J_LAST) s <= (s == S_LAST) ? '0 : s + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        inv_q  <= inv_i;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (load_c && (j == J_LAST)) begin
                        if (s == S_LAST) begin
                            state <= FLUSH;
                        end else begin
`ifdef FFT_AGU_STAGE_BARRIER_EN
                            state    <= WAIT_BAR;
                            bar_pend <= stage_done_i;
`endif
                        end
                    end
                end
`ifdef FFT_AGU_STAGE_BARRIER_EN
                WAIT_BAR: begin
                    if ((bar_pend || stage_done_i) && (!bf_valid_o || bf_ready_i)) begin
                        state    <= RUN;
                        bar_pend <= 1'b0;
                    end else if (stage_done_i) begin
                        bar_pend <= 1'b1;
                    end
                end
`endif
                FLUSH: begin
                    if (xfer_c) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
